// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings, the scoreboard entry layout and the register-hit helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,  // register file
    FWD_EALU = 2'd1,  // ALU result sitting in EX
    FWD_MALU = 2'd2,  // ALU result sitting in MEM
    FWD_MMO  = 2'd3   // load data coming out of MEM
  } fwd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       v;
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // r0 is hard-wired, so it can never be produced by an in-flight instruction.
  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
    return e.v && e.wreg && (e.rn == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding select and load-use detection against the EX and
// MEM scoreboard entries.
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  sb_entry_t  ex_e,
  input  sb_entry_t  mem_e,
  output logic [1:0] fwd,
  output logic       ex_load_hit
);

  logic ex_hit;
  logic mem_hit;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a value held (no latch).
  always_comb begin
    ex_hit      = sb_hit(ex_e, src);
    mem_hit     = sb_hit(mem_e, src);
    fwd         = FWD_REG;
    ex_load_hit = ex_hit && ex_e.m2reg;
    // A load in EX has no data yet; it falls through so the stall logic
    // holds decode until the value appears as FWD_MMO.
    if (ex_hit && !ex_e.m2reg) begin
      fwd = FWD_EALU;
    end else if (mem_hit && !mem_e.m2reg) begin
      fwd = FWD_MALU;
    end else if (mem_hit) begin
      fwd = FWD_MMO;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Decode-side interlock/forwarding scheduler for the 5-stage pipeline:
// shadow scoreboard, forward selects, load-use/MDU stalls and branch squash.
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT    = 4,
  parameter int DELAY_SLOT = 1,
  parameter int SCNT_W     = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic [4:0]        id_rn,
  input  logic              id_mdu_op,
  input  logic              id_hilo_rd,
  input  logic              id_taken,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              nostall,
  output logic              de_bubble,
  output logic              flush_if,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic [SCNT_W-1:0] stall_cnt
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  // The WB-stage result reaches decode through the negative-edge regfile
  // write, so only EX and MEM need shadow state for forwarding and stalls.
  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;

  logic              squash_q, squash_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] rs_fwd, rt_fwd;
  logic       rs_ex_load, rt_ex_load;

  logic squash;
  logic lu_stall;
  logic mdu_stall;
  logic stall;
  logic issue;
  logic taken_issue;

  pipe_fwd_sel u_fwd_rs (
    .src         (id_rs),
    .ex_e        (ex_q),
    .mem_e       (mem_q),
    .fwd         (rs_fwd),
    .ex_load_hit (rs_ex_load)
  );

  pipe_fwd_sel u_fwd_rt (
    .src         (id_rt),
    .ex_e        (ex_q),
    .mem_e       (mem_q),
    .fwd         (rt_fwd),
    .ex_load_hit (rt_ex_load)
  );

  always_comb begin
    mdu_busy    = (cnt_q != '0);
    squash      = (DELAY_SLOT == 0) && squash_q;
    lu_stall    = (id_use_rs && rs_ex_load) || (id_use_rt && rt_ex_load);
    mdu_stall   = (id_mdu_op || id_hilo_rd) && mdu_busy;
    // Both stall causes merge into one stall cycle; reset overrides all.
    stall       = !clr && id_valid && !squash && (lu_stall || mdu_stall);
    issue       = !clr && id_valid && !stall && !squash;
    // A stalled branch only flushes once it actually issues.
    taken_issue = (DELAY_SLOT == 0) && issue && id_taken;

    nostall   = !stall;
    de_bubble = clr || stall || squash || !id_valid;
    flush_if  = taken_issue;
    mdu_start = issue && id_mdu_op;
    fwda      = clr ? FWD_REG : rs_fwd;
    fwdb      = clr ? FWD_REG : rt_fwd;
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    ex_d = SB_EMPTY;
    if (issue) begin
      ex_d = '{v: 1'b1, wreg: id_wreg, m2reg: id_m2reg, rn: id_rn};
    end
    mem_d    = ex_q;
    squash_d = taken_issue;

    cnt_d = cnt_q;
    if (mdu_start) begin
      cnt_d = CNT_W'(MDU_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (clr) begin
      ex_q        <= SB_EMPTY;
      mem_q       <= SB_EMPTY;
      squash_q    <= 1'b0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      squash_q    <= squash_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: directed scenarios followed by
// random traffic, all compared against a cycle-indexed issue-history model.
module tb_pipe_hazard_ctl;

  localparam int MDU_LAT    = 4;
  localparam int DELAY_SLOT = 0;
  localparam int SCNT_W     = 4;
  localparam int SCNT_MAX   = (1 << SCNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr;
  logic              id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic              id_mdu_op, id_hilo_rd, id_taken;
  logic [4:0]        id_rs, id_rt, id_rn;
  logic [1:0]        fwda, fwdb;
  logic              nostall, de_bubble, flush_if, mdu_start, mdu_busy;
  logic [SCNT_W-1:0] stall_cnt;

  pipe_hazard_ctl #(
    .MDU_LAT    (MDU_LAT),
    .DELAY_SLOT (DELAY_SLOT),
    .SCNT_W     (SCNT_W)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_wreg    (id_wreg),
    .id_m2reg   (id_m2reg),
    .id_rn      (id_rn),
    .id_mdu_op  (id_mdu_op),
    .id_hilo_rd (id_hilo_rd),
    .id_taken   (id_taken),
    .fwda       (fwda),
    .fwdb       (fwdb),
    .nostall    (nostall),
    .de_bubble  (de_bubble),
    .flush_if   (flush_if),
    .mdu_start  (mdu_start),
    .mdu_busy   (mdu_busy),
    .stall_cnt  (stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what issued on which cycle, when the MDU frees up,
  // when the last taken branch issued, and how many stall cycles happened.
  typedef struct {
    bit valid;
    bit wreg;
    bit load;
    int rn;
  } instr_t;

  instr_t issued [int];
  int     cyc       = 0;
  int     mdu_free  = 0;
  int     taken_cyc = -10;
  int     stalls    = 0;
  bit     m_issue   = 0;
  bit     m_stall   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic instr_t none();
    instr_t i;
    i.valid = 0; i.wreg = 0; i.load = 0; i.rn = 0;
    return i;
  endfunction

  function automatic instr_t at(input int c);
    if (issued.exists(c)) return issued[c];
    return none();
  endfunction

  function automatic bit writes(input instr_t i, input int r);
    return i.valid && i.wreg && (r != 0) && (i.rn == r);
  endfunction

  // Which stage can supply register r to decode right now.
  function automatic int fwd_of(input int r);
    instr_t ex, mem;
    ex  = at(cyc - 1);
    mem = at(cyc - 2);
    if (writes(ex, r) && !ex.load) return 1;
    if (writes(mem, r)) return mem.load ? 3 : 2;
    return 0;
  endfunction

  task automatic settle();
    instr_t ex;
    bit sq, lu, md;
    #1;
    ex = at(cyc - 1);
    sq = (DELAY_SLOT == 0) && (taken_cyc == cyc - 1);
    lu = (id_use_rs && writes(ex, id_rs) && ex.load) ||
         (id_use_rt && writes(ex, id_rt) && ex.load);
    md = (id_mdu_op || id_hilo_rd) && (cyc < mdu_free);
    m_stall = !clr && id_valid && !sq && (lu || md);
    m_issue = !clr && id_valid && !m_stall && !sq;
    check("fwda",      fwda,      clr ? 0 : fwd_of(id_rs));
    check("fwdb",      fwdb,      clr ? 0 : fwd_of(id_rt));
    check("nostall",   nostall,   !m_stall);
    check("de_bubble", de_bubble, clr || m_stall || sq || !id_valid);
    check("flush_if",  flush_if,  m_issue && id_taken && (DELAY_SLOT == 0));
    check("mdu_start", mdu_start, m_issue && id_mdu_op);
    check("mdu_busy",  mdu_busy,  cyc < mdu_free);
    check("stall_cnt", stall_cnt, (stalls > SCNT_MAX) ? SCNT_MAX : stalls);
  endtask

  task automatic tick();
    instr_t i;
    @(posedge clk);
    if (clr) begin
      issued[cyc]     = none();
      issued[cyc - 1] = none();
      mdu_free  = 0;
      taken_cyc = -10;
      stalls    = 0;
    end else begin
      i = none();
      if (m_issue) begin
        i.valid = 1; i.wreg = id_wreg; i.load = id_m2reg; i.rn = int'(id_rn);
        if (id_mdu_op) mdu_free = cyc + MDU_LAT + 1;
        if (id_taken) taken_cyc = cyc;
      end
      issued[cyc] = i;
      if (m_stall) stalls++;
    end
    m_issue = 0;
    m_stall = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_m2reg = 0; id_rn = 0; id_mdu_op = 0; id_hilo_rd = 0;
    id_taken = 0;
  endtask

  // ALU-style instruction: reads rs/rt, optionally writes rn.
  task automatic alu(input int rs, input int rt, input bit wr, input int rn);
    idle();
    id_valid = 1; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = 1; id_use_rt = 1;
    id_wreg = wr; id_rn = 5'(rn);
  endtask

  task automatic load(input int rs, input int rn);
    idle();
    id_valid = 1; id_rs = 5'(rs); id_use_rs = 1; id_wreg = 1; id_m2reg = 1;
    id_rn = 5'(rn);
  endtask

  task automatic mult();
    idle();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_mdu_op = 1;
  endtask

  task automatic mflo(input int rn);
    idle();
    id_valid = 1; id_hilo_rd = 1; id_wreg = 1; id_rn = 5'(rn);
  endtask

  initial begin
    idle();
    clr = 1;
    tick();               // flops are unknown until the first reset edge
    settle();
    check("rst_nostall", nostall, 1);
    check("rst_bubble", de_bubble, 1);
    check("rst_stall_cnt", stall_cnt, 0);
    tick();
    clr = 0;

    // ALU -> ALU forwarding from EX, then from MEM
    alu(1, 2, 1, 3);  settle(); tick();
    alu(3, 5, 1, 4);  settle();
    check("ex_fwd_fwda", fwda, 1);
    check("ex_fwd_nostall", nostall, 1);
    tick();
    alu(3, 6, 1, 8);  settle();
    check("mem_fwd_fwda", fwda, 2);
    tick();

    // Load-use: one bubble, then load data forwarded on both operands
    load(1, 3);       settle(); tick();
    alu(3, 3, 1, 4);  settle();
    check("lu_nostall", nostall, 0);
    check("lu_bubble", de_bubble, 1);
    tick();
    settle();
    check("lu_fwda", fwda, 3);
    check("lu_fwdb", fwdb, 3);
    check("lu_stall_cnt", stall_cnt, 1);
    tick();

    // r0 is never a hazard
    alu(1, 2, 1, 0);  settle(); tick();
    alu(0, 0, 1, 9);  settle();
    check("r0_fwda", fwda, 0);
    check("r0_nostall", nostall, 1);
    tick();

    // MDU: mflo waits out MDU_LAT cycles
    mult();           settle();
    check("mdu_start", mdu_start, 1);
    tick();
    mflo(5);
    for (int k = 0; k < MDU_LAT; k++) begin
      settle();
      check("mdu_wait_nostall", nostall, 0);
      check("mdu_wait_busy", mdu_busy, 1);
      tick();
    end
    settle();
    check("mflo_issue", nostall, 1);
    check("mflo_idle", mdu_busy, 0);
    check("mdu_stall_cnt", stall_cnt, 5);
    tick();

    // Taken branch without delay slot squashes the next instruction
    alu(1, 2, 0, 0); id_taken = 1; settle();
    check("br_flush", flush_if, 1);
    tick();
    alu(1, 2, 1, 7);  settle();
    check("slot_bubble", de_bubble, 1);
    tick();
    alu(7, 7, 1, 10); settle();
    check("slot_no_entry", fwda, 0);
    tick();

    // Stalled branch does not flush until it issues
    load(1, 3);       settle(); tick();
    alu(3, 2, 0, 0); id_taken = 1; settle();
    check("stalled_br_noflush", flush_if, 0);
    tick();
    settle();
    check("stalled_br_flush", flush_if, 1);
    tick();
    idle(); settle(); tick();

    // Reset during an MDU count with a load in EX
    mult();           settle(); tick();
    load(1, 9);       settle(); tick();
    alu(9, 9, 1, 11); clr = 1; settle();
    check("clr_fwda", fwda, 0);
    check("clr_nostall", nostall, 1);
    tick();
    clr = 0;
    alu(9, 9, 1, 11); id_hilo_rd = 1; settle();
    check("post_clr_busy", mdu_busy, 0);
    check("post_clr_nostall", nostall, 1);
    check("post_clr_stall_cnt", stall_cnt, 0);
    tick();

    // Saturation of the stall counter: 4 x MDU_LAT stalls exceeds 15
    for (int r = 0; r < 4; r++) begin
      mult(); settle(); tick();
      mflo(5);
      for (int k = 0; k <= MDU_LAT; k++) begin
        settle(); tick();
      end
    end
    idle(); settle();
    check("stall_cnt_sat", stall_cnt, SCNT_MAX);
    tick();

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_use_rs  = 1'($urandom_range(0, 1));
      id_use_rt  = 1'($urandom_range(0, 1));
      id_wreg    = 1'($urandom_range(0, 1));
      id_m2reg   = ($urandom_range(0, 3) == 0);
      id_rn      = 5'($urandom_range(0, 3));
      id_mdu_op  = ($urandom_range(0, 7) == 0);
      id_hilo_rd = ($urandom_range(0, 5) == 0);
      id_taken   = ($urandom_range(0, 7) == 0);
      clr        = ($urandom_range(0, 63) == 0);
      settle();
      tick();
    end
    clr = 0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Central interlock/forwarding scheduler for the 5-stage pipeline.
- Keeps its own shadow scoreboard of the destination registers in flight in EX, MEM and WB.
- From it, generates the decode-stage operand forwarding selects, load-use and multi-cycle-unit stalls, bubble insertion and control-flow squash.
- Sits beside the decode stage and replaces its ad-hoc hazard logic; drives PC/IR write enables and the decode→execute pipeline register.

Parameters:
- MDU_LAT, 4, cycles a multiply/divide occupies the MDU (≥1).
- DELAY_SLOT, 1, 1 = branch delay slot executes; 0 = instruction after a taken branch/jump is squashed.
- SCNT_W, 16, width of saturating stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  synchronous active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  5  rs field of decode instruction.
- id_rt  in  5  rt field of decode instruction.
- id_use_rs  in  1  instruction reads rs (ALU operand or branch compare).
- id_use_rt  in  1  instruction reads rt.
- id_wreg  in  1  instruction writes the register file.
- id_m2reg  in  1  instruction is a load.
- id_rn  in  5  destination register number.
- id_mdu_op  in  1  instruction starts a multiply/divide.
- id_hilo_rd  in  1  instruction reads HI/LO (mfhi/mflo).
- id_taken  in  1  decode resolved a taken branch/jump (pcsource≠0).
- fwda  out  2  rs source select: 0 regfile, 1 ealu, 2 malu, 3 mmo.
- fwdb  out  2  rt source select, same encoding.
- nostall  out  1  1 = PC and IF/ID register advance.
- de_bubble  out  1  load a bubble into the decode→execute register this cycle.
- flush_if  out  1  turn the IF/ID register into a bubble on this edge.
- mdu_start  out  1  one-cycle pulse launching the MDU.
- mdu_busy  out  1  MDU occupied.
- stall_cnt  out  SCNT_W  count of stall cycles, saturating.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset clr is synchronous and active-high.
- Scoreboard: three entries ex, mem, wb, each {v, wreg, m2reg, rn}.
  - Every edge: wb←mem, mem←ex.
  - ex←{id_valid, id_wreg, id_m2reg, id_rn} when `issue`; otherwise ex←0 (bubble).
  - issue = id_valid & nostall & ~squash.
- Hit rule: a match requires v & wreg & rn==reg & reg≠0. Register 0 never matches, never forwards, never stalls.
- Forward, per operand X∈{rs,rt}; first match wins:
  - ex hit & ~ex.m2reg → 1
  - mem hit & ~mem.m2reg → 2
  - mem hit & mem.m2reg → 3
  - else → 0
  - wb is not forwarded; the regfile writes on the negative edge.
- Load-use stall: id_use_X & ex hit on X & ex.m2reg.
- MDU stall: (id_mdu_op | id_hilo_rd) & mdu_busy.
- Stall terms:
  - stall = id_valid & ~squash & (load-use | MDU stall).
  - nostall = ~stall.
  - de_bubble = stall | squash | ~id_valid.
- MDU counter:
  - mdu_start = issue & id_mdu_op; this loads cnt←MDU_LAT.
  - Otherwise cnt decrements toward 0.
  - mdu_busy = cnt≠0; the HI/LO reader issues on the cycle cnt reaches 0.
- Squash:
  - DELAY_SLOT=0: squash register ← issue & id_taken. flush_if = issue & id_taken.
  - DELAY_SLOT=1: squash and flush_if are tied 0.
  - A stalled instruction with id_taken does not flush until it issues.
- stall_cnt increments on each stall cycle and holds at all-ones.
- Reset, on the edge with clr=1: scoreboard entries, squash and cnt cleared; stall_cnt←0.
- Outputs while clr is high: nostall=1, fwda=fwdb=0, flush_if=0, mdu_start=0, de_bubble=1.
- Reset mid-MDU aborts the count.
- Simultaneous load-use and MDU stall count as one stall cycle.
- Latency: forwards and stalls are combinational from the id_* inputs and scoreboard state; scoreboard update takes one cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - the fwd encodings FWD_REG/FWD_EALU/FWD_MALU/FWD_MMO;
  - a scoreboard-entry struct type;
  - REG_ZERO=5'd0.
- One natural sub-module: pipe_fwd_sel, the combinational per-operand forward/hit logic, instantiated twice (rs, rt).

Test Plan:
- add r3 issued, then sub r4,r3,r5 next cycle → fwda=1, nostall=1. Two cycles after the add → fwda=2.
- lw r3 then add r4,r3,r3 → one cycle nostall=0, de_bubble=1. Next cycle fwda=fwdb=3, stall_cnt=1.
- Producer writes r0, consumer reads r0 → fwda=0, no stall.
- mult issued, MDU_LAT=4, then mflo → mdu_start pulse; nostall=0 for 4 cycles; mflo issues when cnt=0; stall_cnt=4.
- DELAY_SLOT=0, taken beq issued → flush_if=1 that cycle; next cycle de_bubble=1 and no scoreboard entry is created for the slot instruction.
- clr asserted during an MDU count and with a pending load in ex → next cycle mdu_busy=0, no stall for a dependent instruction, stall_cnt=0.
